// File: rtl/cache_pkg.sv
// Shared types and derived geometry for the direct-mapped write-through cache.
package cache_pkg;

   localparam int DATA_W               = 32;
   localparam int DEF_CACHE_LINE_WIDTH = 4;
   localparam int DEF_TAG_WIDTH        = 24;
   localparam int DEF_ADDR_WIDTH       = 32;
   localparam int INDEX_WIDTH          = DEF_ADDR_WIDTH - DEF_TAG_WIDTH - DEF_CACHE_LINE_WIDTH;
   localparam int WORDS_PER_LINE       = 2 ** (DEF_CACHE_LINE_WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL_REQ  = 2'd1,
      FILL_DATA = 2'd2,
      WRITE     = 2'd3
   } state_t;

   function automatic int index_width(input int aw, input int tw, input int lw);
      return aw - tw - lw;
   endfunction

   function automatic int words_per_line(input int lw);
      return 2 ** (lw - 2);
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: one synchronous write port, two combinational read ports.
// Reads have zero latency; writes land on the rising edge and are visible the next cycle.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int TAG_W  = 24,
   parameter int IDX_W  = 4,
   parameter int WORD_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [WORD_W-1:0] i_wr_word,
   input  logic [DATA_W-1:0] i_wr_dat,
   input  logic              i_line_upd,
   input  logic              i_line_vld,
   input  logic [TAG_W-1:0]  i_line_tag,
   input  logic [IDX_W-1:0]  i_rd0_idx,
   input  logic [WORD_W-1:0] i_rd0_word,
   output logic              o_rd0_vld,
   output logic [TAG_W-1:0]  o_rd0_tag,
   output logic [DATA_W-1:0] o_rd0_dat,
   input  logic [IDX_W-1:0]  i_rd1_idx,
   input  logic [WORD_W-1:0] i_rd1_word,
   output logic              o_rd1_vld,
   output logic [TAG_W-1:0]  o_rd1_tag,
   output logic [DATA_W-1:0] o_rd1_dat
);

   localparam int LINES = 2 ** IDX_W;
   localparam int WORDS = 2 ** WORD_W;

   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [DATA_W-1:0] r_data [LINES*WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (i_line_upd) begin
         r_valid[i_wr_idx] <= i_line_vld;
      end
   end

   always_ff @(posedge clk) begin
      if (i_line_upd && i_line_vld) begin
         r_tag[i_wr_idx] <= i_line_tag;
      end
      if (i_wr_en) begin
         r_data[{i_wr_idx, i_wr_word}] <= i_wr_dat;
      end
   end

   assign o_rd0_vld = r_valid[i_rd0_idx];
   assign o_rd0_tag = r_tag[i_rd0_idx];
   assign o_rd0_dat = r_data[{i_rd0_idx, i_rd0_word}];
   assign o_rd1_vld = r_valid[i_rd1_idx];
   assign o_rd1_tag = r_tag[i_rd1_idx];
   assign o_rd1_dat = r_data[{i_rd1_idx, i_rd1_word}];

endmodule

// File: rtl/cache.sv
// Direct-mapped write-through cache with a read/write and a read-only Avalon slave.
// Read hits answer in the same cycle; misses and writes stall the requesting port via waitrequest.
module cache
   import cache_pkg::*;
#(
   parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
   parameter int TAG_WIDTH        = DEF_TAG_WIDTH,
   parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     avalon_slave_address,
   input  logic                      avalon_slave_read,
   input  logic                      avalon_slave_write,
   input  logic [31:0]               avalon_slave_writedata,
   output logic [31:0]               avalon_slave_readdata,
   output logic                      avalon_slave_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     avalon_rdslave_address,
   input  logic                      avalon_rdslave_read,
   output logic [31:0]               avalon_rdslave_readdata,
   output logic                      avalon_rdslave_waitrequest,
   output logic [ADDR_WIDTH-1:0]     avalon_master_address,
   output logic [CACHE_LINE_WIDTH-2:0] avalon_master_burstcount,
   output logic                      avalon_master_read,
   output logic                      avalon_master_write,
   output logic [31:0]               avalon_master_writedata,
   input  logic [31:0]               avalon_master_readdata,
   input  logic                      avalon_master_waitrequest,
   input  logic                      avalon_master_readdatavalid
);

   localparam int IDX_W  = index_width(ADDR_WIDTH, TAG_WIDTH, CACHE_LINE_WIDTH);
   localparam int WORD_W = CACHE_LINE_WIDTH - 2;
   localparam int WPL    = words_per_line(CACHE_LINE_WIDTH);
   localparam int BC_W   = CACHE_LINE_WIDTH - 1;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_miss_addr, w_miss_addr_nxt;
   logic [WORD_W-1:0]     r_beat;

   logic [TAG_WIDTH-1:0]  w_s_tag, w_r_tag, w_m_tag, w_s_ltag, w_r_ltag;
   logic [IDX_W-1:0]      w_s_idx, w_r_idx, w_m_idx, w_wr_idx;
   logic [WORD_W-1:0]     w_s_word, w_r_word, w_wr_word;
   logic [31:0]           w_s_dat, w_r_dat, w_wr_dat;
   logic                  w_s_vld, w_r_vld, w_s_hit, w_r_hit, w_s_rd_miss, w_r_miss;
   logic                  w_wr_en, w_line_upd, w_line_vld;
   logic                  w_unused;

   assign w_s_tag  = avalon_slave_address[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign w_s_idx  = avalon_slave_address[CACHE_LINE_WIDTH +: IDX_W];
   assign w_s_word = avalon_slave_address[CACHE_LINE_WIDTH-1:2];
   assign w_r_tag  = avalon_rdslave_address[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign w_r_idx  = avalon_rdslave_address[CACHE_LINE_WIDTH +: IDX_W];
   assign w_r_word = avalon_rdslave_address[CACHE_LINE_WIDTH-1:2];
   assign w_m_tag  = r_miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign w_m_idx  = r_miss_addr[CACHE_LINE_WIDTH +: IDX_W];
   assign w_unused = &{1'b0, avalon_slave_address[1:0], avalon_rdslave_address[1:0]};

   cache_line_store #(
      .TAG_W (TAG_WIDTH),
      .IDX_W (IDX_W),
      .WORD_W(WORD_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_word (w_wr_word),
      .i_wr_dat  (w_wr_dat),
      .i_line_upd(w_line_upd),
      .i_line_vld(w_line_vld),
      .i_line_tag(w_m_tag),
      .i_rd0_idx (w_s_idx),
      .i_rd0_word(w_s_word),
      .o_rd0_vld (w_s_vld),
      .o_rd0_tag (w_s_ltag),
      .o_rd0_dat (w_s_dat),
      .i_rd1_idx (w_r_idx),
      .i_rd1_word(w_r_word),
      .o_rd1_vld (w_r_vld),
      .o_rd1_tag (w_r_ltag),
      .o_rd1_dat (w_r_dat)
   );

   assign w_s_hit     = w_s_vld && (w_s_ltag == w_s_tag);
   assign w_r_hit     = w_r_vld && (w_r_ltag == w_r_tag);
   assign w_s_rd_miss = avalon_slave_read && !avalon_slave_write && !w_s_hit;
   assign w_r_miss    = avalon_rdslave_read && !w_r_hit;

   // A write stalls the slave until the master accepts it; reads stall only on a miss.
   assign avalon_slave_waitrequest   = avalon_slave_write
                                     ? !(r_state == WRITE && !avalon_master_waitrequest)
                                     : (avalon_slave_read && !w_s_hit);
   assign avalon_slave_readdata      = (avalon_slave_read && !avalon_slave_write && w_s_hit) ? w_s_dat : '0;
   assign avalon_rdslave_waitrequest = w_r_miss;
   assign avalon_rdslave_readdata    = (avalon_rdslave_read && w_r_hit) ? w_r_dat : '0;

   always_comb begin
      w_next                   = r_state;
      w_miss_addr_nxt          = r_miss_addr;
      w_wr_en                  = 1'b0;
      w_wr_idx                 = w_m_idx;
      w_wr_word                = r_beat;
      w_wr_dat                 = avalon_master_readdata;
      w_line_upd               = 1'b0;
      w_line_vld               = 1'b0;
      avalon_master_address    = '0;
      avalon_master_burstcount = '0;
      avalon_master_read       = 1'b0;
      avalon_master_write      = 1'b0;
      avalon_master_writedata  = '0;
      case (r_state)
         IDLE: begin
            if (avalon_slave_write) begin
               w_next = WRITE;
            end else if (w_s_rd_miss) begin
               w_next          = FILL_REQ;
               w_miss_addr_nxt = {avalon_slave_address[ADDR_WIDTH-1:CACHE_LINE_WIDTH], {CACHE_LINE_WIDTH{1'b0}}};
            end else if (w_r_miss) begin
               w_next          = FILL_REQ;
               w_miss_addr_nxt = {avalon_rdslave_address[ADDR_WIDTH-1:CACHE_LINE_WIDTH], {CACHE_LINE_WIDTH{1'b0}}};
            end
         end
         FILL_REQ: begin
            avalon_master_read       = 1'b1;
            avalon_master_address    = r_miss_addr;
            avalon_master_burstcount = BC_W'(WPL);
            if (!avalon_master_waitrequest) w_next = FILL_DATA;
         end
         FILL_DATA: begin
            // The line stays invalid until its last beat so a half-filled line never hits.
            if (avalon_master_readdatavalid) begin
               w_wr_en    = 1'b1;
               w_line_upd = 1'b1;
               w_line_vld = (r_beat == WORD_W'(WPL - 1));
               if (w_line_vld) w_next = IDLE;
            end
         end
         WRITE: begin
            avalon_master_write      = 1'b1;
            avalon_master_address    = avalon_slave_address;
            avalon_master_burstcount = BC_W'(1);
            avalon_master_writedata  = avalon_slave_writedata;
            if (!avalon_master_waitrequest) begin
               w_next    = IDLE;
               w_wr_en   = w_s_hit;
               w_wr_idx  = w_s_idx;
               w_wr_word = w_s_word;
               w_wr_dat  = avalon_slave_writedata;
            end
         end
         default: w_next = IDLE;
      endcase
      if (rst) begin
         avalon_master_address    = '0;
         avalon_master_burstcount = '0;
         avalon_master_read       = 1'b0;
         avalon_master_write      = 1'b0;
         avalon_master_writedata  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_miss_addr <= '0;
         r_beat      <= '0;
      end else begin
         r_state     <= w_next;
         r_miss_addr <= w_miss_addr_nxt;
         if (r_state == FILL_REQ) begin
            r_beat <= '0;
         end else if (r_state == FILL_DATA && avalon_master_readdatavalid) begin
            r_beat <= r_beat + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache.sv
// Randomized bench: memory-backed master responder plus a tag/data reference model of the cache.
module tb_cache;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_addr = '0, s_wdata = '0, s_rdata;
   logic        s_read = 1'b0, s_write = 1'b0, s_wait;
   logic [31:0] r_addr = '0, r_rdata;
   logic        r_read = 1'b0, r_wait;
   logic [31:0] m_addr, m_wdata, m_rdata = '0;
   logic [2:0]  m_burst;
   logic        m_read, m_write, m_wait = 1'b1, m_rdv = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [31:0] ext_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic        mvalid [2**INDEX_WIDTH];
   logic [23:0] mtag   [2**INDEX_WIDTH];

   logic [31:0] fill_q[$];
   int          beats_left = 0, beat_idx = 0, burst_beats = 0;
   logic [31:0] fill_base = '0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr = '0, wr_dat = '0;
   logic [2:0]  wr_burst = '0;

   always #5 clk = ~clk;

   cache #(.CACHE_LINE_WIDTH(4), .TAG_WIDTH(24), .ADDR_WIDTH(32)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .avalon_slave_address       (s_addr),
      .avalon_slave_read          (s_read),
      .avalon_slave_write         (s_write),
      .avalon_slave_writedata     (s_wdata),
      .avalon_slave_readdata      (s_rdata),
      .avalon_slave_waitrequest   (s_wait),
      .avalon_rdslave_address     (r_addr),
      .avalon_rdslave_read        (r_read),
      .avalon_rdslave_readdata    (r_rdata),
      .avalon_rdslave_waitrequest (r_wait),
      .avalon_master_address      (m_addr),
      .avalon_master_burstcount   (m_burst),
      .avalon_master_read         (m_read),
      .avalon_master_write        (m_write),
      .avalon_master_writedata    (m_wdata),
      .avalon_master_readdata     (m_rdata),
      .avalon_master_waitrequest  (m_wait),
      .avalon_master_readdatavalid(m_rdv)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ext_get(input logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      if (ext_mem.exists(k)) return ext_mem[k];
      return init_word(k);
   endfunction

   function automatic logic [31:0] ref_get(input logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      if (ref_mem.exists(k)) return ref_mem[k];
      return init_word(k);
   endfunction

   function automatic bit mhit(input logic [31:0] a);
      return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a = '0;
      a[9:8] = 2'($urandom_range(0, 2));
      a[7:0] = 8'($urandom);
      return a;
   endfunction

   // Memory-side responder: random stalls, gapped burst beats, hold checks on stalled requests.
   initial begin
      logic        prev_req = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
      logic [31:0] prev_addr = '0;
      logic [2:0]  prev_burst = '0;
      forever begin
         @(negedge clk);
         m_wait = ($urandom_range(0, 2) == 0);
         if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
            m_rdv = 1'b1;
            m_rdata = ext_get(fill_base + 32'(4 * beat_idx));
            beat_idx++;
            beats_left--;
            burst_beats++;
         end else begin
            m_rdv = 1'b0;
            m_rdata = $urandom;
         end
         #1;
         if (prev_req && !rst) begin
            check_eq("hold_addr", m_addr, prev_addr);
            check_eq("hold_ctl", {29'd0, m_read, m_write, 1'b0}, {29'd0, prev_rd, prev_wr, 1'b0});
            check_eq("hold_burst", {29'd0, m_burst}, {29'd0, prev_burst});
         end
         prev_req   = !rst && (m_read || m_write) && m_wait;
         prev_rd    = m_read;
         prev_wr    = m_write;
         prev_addr  = m_addr;
         prev_burst = m_burst;
         if (!rst && m_read && !m_wait) begin
            fill_q.push_back(m_addr);
            check_eq("fill_burst", {29'd0, m_burst}, 32'd4);
            beats_left  = 4;
            beat_idx    = 0;
            burst_beats = 0;
            fill_base   = m_addr;
         end
         if (!rst && m_write && !m_wait) begin
            wr_cnt++;
            wr_addr  = m_addr;
            wr_dat   = m_wdata;
            wr_burst = m_burst;
            ext_mem[{m_addr[31:2], 2'b00}] = m_wdata;
         end
      end
   end

   task automatic access(input bit s_en, input logic [31:0] s_a, input bit r_en, input logic [31:0] r_a);
      bit          s_hit0, r_hit0, s_done, r_done, s_first, r_first;
      int          exp_fills, f0, cyc, leak;
      logic [31:0] exp_first, s_dat, r_dat;
      s_hit0 = mhit(s_a);
      r_hit0 = mhit(r_a);
      exp_fills = 0;
      exp_first = '0;
      if (s_en && !s_hit0) begin
         exp_fills++;
         exp_first = {s_a[31:4], 4'h0};
         mvalid[s_a[7:4]] = 1'b1;
         mtag[s_a[7:4]]   = s_a[31:8];
      end
      if (r_en && !r_hit0 && !mhit(r_a)) begin
         if (exp_fills == 0) exp_first = {r_a[31:4], 4'h0};
         exp_fills++;
         mvalid[r_a[7:4]] = 1'b1;
         mtag[r_a[7:4]]   = r_a[31:8];
      end
      f0 = fill_q.size();
      leak = 0;
      s_first = 0; r_first = 0; s_dat = '0; r_dat = '0;
      @(negedge clk);
      s_read = s_en; s_addr = s_a; r_read = r_en; r_addr = r_a;
      s_done = !s_en; r_done = !r_en; cyc = 0;
      while (!(s_done && r_done) && cyc < 200) begin
         #2;
         if (!s_en && (s_wait || s_rdata != 0)) leak++;
         if (!r_en && (r_wait || r_rdata != 0)) leak++;
         if (!s_done) begin
            if (!s_wait) begin s_done = 1; s_dat = s_rdata; s_first = (cyc == 0); end
            else if (s_rdata != 0) leak++;
         end
         if (!r_done) begin
            if (!r_wait) begin r_done = 1; r_dat = r_rdata; r_first = (cyc == 0); end
            else if (r_rdata != 0) leak++;
         end
         @(negedge clk);
         cyc++;
         if (s_done) s_read = 1'b0;
         if (r_done) r_read = 1'b0;
      end
      s_read = 1'b0; r_read = 1'b0;
      if (!(s_done && r_done)) check_eq("rd_timeout", 32'd0, 32'd1);
      check_eq("rd_leak", 32'(leak), 32'd0);
      if (s_en) begin
         check_eq("s_hit", {31'd0, s_first}, {31'd0, s_hit0});
         check_eq("s_data", s_dat, ref_get(s_a));
      end
      if (r_en) begin
         check_eq("r_hit", {31'd0, r_first}, {31'd0, r_hit0});
         check_eq("r_data", r_dat, ref_get(r_a));
      end
      check_eq("fill_n", 32'(fill_q.size() - f0), 32'(exp_fills));
      if (exp_fills > 0 && fill_q.size() > f0) begin
         check_eq("fill_addr", fill_q[f0], exp_first);
         check_eq("fill_beats", 32'(burst_beats), 32'd4);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_rd);
      bit hit0, done;
      int f0, w0, cyc;
      hit0 = mhit(a);
      f0 = fill_q.size();
      w0 = wr_cnt;
      @(negedge clk);
      s_write = 1'b1; s_read = with_rd; s_addr = a; s_wdata = d;
      done = 0; cyc = 0;
      while (!done && cyc < 200) begin
         #2;
         if (!s_wait) done = 1;
         @(negedge clk);
         cyc++;
      end
      s_write = 1'b0; s_read = 1'b0;
      ref_mem[{a[31:2], 2'b00}] = d;
      if (!done) check_eq("wr_timeout", 32'd0, 32'd1);
      check_eq("wr_count", 32'(wr_cnt - w0), 32'd1);
      check_eq("wr_addr", wr_addr, a);
      check_eq("wr_data", wr_dat, d);
      check_eq("wr_burst", {29'd0, wr_burst}, 32'd1);
      check_eq("wr_nofill", 32'(fill_q.size() - f0), 32'd0);
      if (hit0) begin
         r_read = 1'b1; r_addr = a;
         #2;
         check_eq("wr_visible_wait", {31'd0, r_wait}, 32'd0);
         check_eq("wr_visible_data", r_rdata, d);
         @(negedge clk);
         r_read = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2**INDEX_WIDTH; i++) mvalid[i] = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_mctl"}, {29'd0, m_read, m_write, 1'b0}, 32'd0);
      check_eq({tag, "_maddr"}, m_addr, 32'd0);
      check_eq({tag, "_mburst"}, {29'd0, m_burst}, 32'd0);
      check_eq({tag, "_swait"}, {31'd0, s_wait}, 32'd0);
      check_eq({tag, "_sdata"}, s_rdata, 32'd0);
      check_eq({tag, "_rwait"}, {31'd0, r_wait}, 32'd0);
      check_eq({tag, "_rdata"}, r_rdata, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, cyc;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      check_idle("reset");

      access(1, 32'h0C, 1, 32'h14);
      access(1, 32'h0C, 0, 32'h0);
      access(1, 32'h20, 0, 32'h0);
      do_write(32'h20, 32'hDEADBEEF, 0);
      access(0, 32'h0, 1, 32'h20);
      access(1, 32'h000, 0, 32'h0);
      access(1, 32'h100, 0, 32'h0);
      access(1, 32'h000, 0, 32'h0);
      do_write(32'h300, 32'h0BADF00D, 0);
      access(1, 32'h300, 0, 32'h0);

      // Reset in the middle of a fill, after two beats have been delivered.
      f0 = fill_q.size();
      @(negedge clk);
      s_read = 1'b1; s_addr = 32'h44;
      cyc = 0;
      while (!(fill_q.size() > f0 && burst_beats >= 2) && cyc < 200) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      if (cyc >= 200) check_eq("rst_fill_timeout", 32'd0, 32'd1);
      @(negedge clk);
      rst = 1'b1; s_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #2;
      check_idle("midfill");
      access(0, 32'h0, 1, 32'h44);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0: access(1, rand_addr(), 0, 32'h0);
            1: access(0, 32'h0, 1, rand_addr());
            2: access(1, rand_addr(), 1, rand_addr());
            default: do_write(rand_addr(), $urandom, 1'($urandom_range(0, 1)));
         endcase
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
